// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl_if
// Purpose  : Request/response bundle between a load/store unit (master) and
//            the data memory controller (slave).
// Signals  : req        - request strobe (master -> slave)
//            we         - 1 = store, 0 = load
//            size       - access size / extension code
//            addr       - byte address
//            write_data - store data (low byte/half for SB/SH)
//            busy       - transaction in flight, req ignored (slave -> master)
//            done       - one-cycle response pulse
//            err        - access rejected, valid with done
//            read_data  - load result, valid with done
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] read_data;

  modport master (
    output req, we, size, addr, write_data,
    input  busy, done, err, read_data
  );

  modport slave (
    input  req, we, size, addr, write_data,
    output busy, done, err, read_data
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Byte-addressable data memory with req/busy/done handshake,
//            programmable wait states and RISC-V style sized accesses
//            (LB/LH/LW/LBU/LHU, SB/SH/SW). Misaligned, out-of-range and
//            illegal-size accesses are rejected with err instead of aliasing.
// Ports    : clk   - clock, all state updates on rising edge
//            rst_n - synchronous active-low reset
//            bus   - data_mem_ctrl_if slave modport (request in, response out)
// Params   : DEPTH_BYTES - memory size in bytes (power of two, >= 4)
//            WAIT_CYCLES - extra cycles between acceptance and response (0-15)
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  data_mem_ctrl_if.slave  bus
);

  localparam int          AW          = $clog2(DEPTH_BYTES);
  localparam logic        c_ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [32:0] c_DEPTH     = 33'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  logic [7:0]  r_mem [DEPTH_BYTES];

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;

  // With zero wait states the access commits on the accepting edge, so the
  // live inputs are used; otherwise the operands latched at acceptance are.
  logic        w_in_idle;
  logic        w_we;
  logic [2:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_commit;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_we      = w_in_idle ? bus.we         : r_we;
  assign w_size    = w_in_idle ? bus.size       : r_size;
  assign w_addr    = w_in_idle ? bus.addr       : r_addr;
  assign w_wdata   = w_in_idle ? bus.write_data : r_wdata;

  assign w_commit  = (w_in_idle && bus.req && c_ZERO_WAIT) ||
                     ((r_state == ST_WAIT) && (r_cnt == 4'd0));

  // Access decode and error check
  logic [2:0]  w_nbytes;
  logic        w_illegal;
  logic        w_misal;
  logic [32:0] w_end;
  logic        w_err;

  always_comb begin
    w_nbytes  = 3'd1;
    w_illegal = 1'b1;
    case (w_size)
      3'b000, 3'b100: begin w_nbytes = 3'd1; w_illegal = 1'b0; end
      3'b001, 3'b101: begin w_nbytes = 3'd2; w_illegal = 1'b0; end
      3'b010:         begin w_nbytes = 3'd4; w_illegal = 1'b0; end
      default:        begin w_nbytes = 3'd1; w_illegal = 1'b1; end
    endcase
  end

  assign w_misal = ((w_nbytes == 3'd2) && w_addr[0]) ||
                   ((w_nbytes == 3'd4) && (w_addr[1:0] != 2'b00));
  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign w_end   = {1'b0, w_addr} + 33'(w_nbytes);
  assign w_err   = w_illegal | w_misal | (w_end > c_DEPTH);

  // Little-endian byte lanes; indices wrap only for accesses already rejected
  logic [AW-1:0] w_idx [4];
  logic [7:0]    w_b   [4];
  logic [31:0]   w_load;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = w_addr[AW-1:0] + AW'(k);
      w_b[k]   = r_mem[w_idx[k]];
    end
  end

  always_comb begin
    w_load = {w_b[3], w_b[2], w_b[1], w_b[0]};
    case (w_size)
      3'b000:  w_load = {{24{w_b[0][7]}}, w_b[0]};
      3'b001:  w_load = {{16{w_b[1][7]}}, w_b[1], w_b[0]};
      3'b100:  w_load = {24'd0, w_b[0]};
      3'b101:  w_load = {16'd0, w_b[1], w_b[0]};
      default: w_load = {w_b[3], w_b[2], w_b[1], w_b[0]};
    endcase
  end

  // Store commit; reset on the commit edge drops the store
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && !w_err && w_we) begin
      r_mem[w_idx[0]] <= w_wdata[7:0];
      if (w_nbytes != 3'd1) begin
        r_mem[w_idx[1]] <= w_wdata[15:8];
      end
      if (w_nbytes == 3'd4) begin
        r_mem[w_idx[2]] <= w_wdata[23:16];
        r_mem[w_idx[3]] <= w_wdata[31:24];
      end
    end
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_addr  <= bus.addr;
            r_wdata <= bus.write_data;
            r_cnt   <= c_WAIT_LOAD;
            r_state <= c_ZERO_WAIT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_commit) begin
        r_done  <= 1'b1;
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
      end
    end
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.read_data = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Self-checking bench for data_mem_ctrl. A WAIT_CYCLES=1 instance
//            is driven with directed and random accesses; expected responses
//            come from a byte-array reference model and are queued for a
//            monitor that checks them when done pulses. WAIT_CYCLES=0 and 3
//            instances cover back-to-back handshake timing and reset
//            during an in-flight store.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_n3;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl_if if0 ();
  data_mem_ctrl_if if1 ();
  data_mem_ctrl_if if3 ();

  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst_n(rst_n),  .bus(if0.slave));
  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n),  .bus(if1.slave));
  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst_n(rst_n3), .bus(if3.slave));

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model (WAIT_CYCLES=1 instance) ----------------
  bit [7:0] ref_mem [DEPTH];

  function automatic int size_bytes(input bit [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic void model(input bit we, input bit [2:0] size, input bit [31:0] addr,
                                input bit [31:0] wd, output bit err, output bit [31:0] rd);
    int     nb;
    longint a;
    longint v;
    nb  = size_bytes(size);
    a   = longint'(addr);
    err = 1'b0;
    rd  = 32'd0;
    if (nb == 0)                err = 1'b1;
    else if ((a % nb) != 0)     err = 1'b1;
    else if (a + nb > DEPTH)    err = 1'b1;
    if (err) return;
    if (we) begin
      for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = 8'((wd >> (8 * k)) & 32'hFF);
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v = v + (longint'(ref_mem[int'(a) + k]) << (8 * k));
      if (size == 3'd0 && v >= 128)   v = v - 256;
      if (size == 3'd1 && v >= 32768) v = v - 65536;
      rd = v[31:0];
    end
  endfunction

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    bit        err;
    bit [31:0] rd;
    int        cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && if1.done) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no response", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("resp_err",   {31'd0, if1.err}, {31'd0, mon_e.err});
        check("resp_rdata", if1.read_data, mon_e.rd);
        check("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic wait_idle1();
    for (int i = 0; i < 40 && if1.busy; i++) @(negedge clk);
    if (if1.busy) begin
      total++;
      $display("FAIL idle1_timeout: got busy=1 expected busy=0 within 40 cycles");
    end
  endtask

  // Issue one access on the WAIT_CYCLES=1 instance; called at a negedge.
  task automatic issue1(input bit we, input bit [2:0] size, input bit [31:0] addr, input bit [31:0] wd);
    exp_t      e;
    bit        err;
    bit [31:0] rd;
    wait_idle1();
    model(we, size, addr, wd, err, rd);
    e.err = err;
    e.rd  = rd;
    e.cyc = cyc + 2;   // accept at next edge, response one wait cycle later
    sb.push_back(e);
    if1.req = 1'b1; if1.we = we; if1.size = size; if1.addr = addr; if1.write_data = wd;
    @(negedge clk);
    check("busy_after_accept", {31'd0, if1.busy}, 32'd1);
    if1.req = 1'b0; if1.addr = $urandom(); if1.write_data = $urandom(); if1.size = 3'($urandom());
  endtask

  // ---------------- WAIT_CYCLES=3 helper ----------------
  task automatic txn3(input bit we, input bit [2:0] size, input bit [31:0] addr, input bit [31:0] wd,
                      output bit got, output bit err, output bit [31:0] rd);
    got = 1'b0; err = 1'b0; rd = 32'd0;
    for (int i = 0; i < 20 && if3.busy; i++) @(negedge clk);
    if3.req = 1'b1; if3.we = we; if3.size = size; if3.addr = addr; if3.write_data = wd;
    @(negedge clk);
    if3.req = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (if3.done) begin got = 1'b1; err = if3.err; rd = if3.read_data; end
      else @(negedge clk);
    end
  endtask

  function automatic bit hs_exp(input int i, input int w);
    return (i >= w + 1) && (((i - (w + 1)) % (w + 2)) == 0);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  bit [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    bit          got, err, sawdone;
    bit [31:0]   rd, addr;
    bit [2:0]    size;
    int          nb;

    rst_n = 1'b0; rst_n3 = 1'b0;
    if0.req = 1'b1; if0.we = 1'b0; if0.size = 3'd2; if0.addr = 32'd0; if0.write_data = 32'd0;
    if1.req = 1'b1; if1.we = 1'b1; if1.size = 3'd2; if1.addr = 32'd0; if1.write_data = 32'hFFFFFFFF;
    if3.req = 1'b1; if3.we = 1'b0; if3.size = 3'd2; if3.addr = 32'd0; if3.write_data = 32'd0;

    // Reset with req asserted
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_busy",  {31'd0, if1.busy}, 32'd0);
      check("rst_done",  {31'd0, if1.done}, 32'd0);
      check("rst_err",   {31'd0, if1.err},  32'd0);
      check("rst_rdata", if1.read_data,     32'd0);
    end
    if0.req = 1'b0; if1.req = 1'b0; if3.req = 1'b0;
    rst_n = 1'b1; rst_n3 = 1'b1;
    @(negedge clk);

    // Give every byte a known value
    for (int a = 0; a < DEPTH; a += 4) issue1(1'b1, 3'd2, 32'(a), $urandom());

    // Directed accesses
    issue1(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue1(1'b0, 3'd2, 32'h10, 32'd0);
    issue1(1'b0, 3'd0, 32'h13, 32'd0);
    issue1(1'b0, 3'd4, 32'h13, 32'd0);
    issue1(1'b0, 3'd1, 32'h10, 32'd0);
    issue1(1'b0, 3'd5, 32'h12, 32'd0);
    issue1(1'b1, 3'd0, 32'h11, 32'hAAAAAA55);
    issue1(1'b0, 3'd2, 32'h10, 32'd0);
    issue1(1'b0, 3'd2, 32'h02, 32'd0);
    issue1(1'b1, 3'd1, 32'h0F, 32'h12345678);
    issue1(1'b0, 3'd2, 32'h0C, 32'd0);
    issue1(1'b0, 3'd2, 32'(DEPTH - 2), 32'd0);
    issue1(1'b0, 3'd3, 32'h20, 32'd0);
    issue1(1'b0, 3'd2, 32'(DEPTH - 4), 32'd0);
    issue1(1'b0, 3'd2, 32'hFFFFFFFC, 32'd0);
    issue1(1'b1, 3'd0, 32'd0, 32'h000000A7);
    issue1(1'b0, 3'd0, 32'd0, 32'd0);

    // Random accesses
    repeat (400) begin
      if ($urandom_range(0, 4) == 0) size = 3'($urandom_range(0, 7));
      else size = legal[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0:       addr = $urandom();
        1:       addr = 32'(DEPTH - 8 + int'($urandom_range(0, 7)));
        default: addr = 32'($urandom_range(0, DEPTH - 1));
      endcase
      nb = size_bytes(size);
      if (nb > 1 && $urandom_range(0, 3) != 0) addr = addr & ~32'(nb - 1);
      issue1(1'($urandom_range(0, 1)), size, addr, $urandom());
    end
    wait_idle1();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Back-to-back requests, WAIT_CYCLES=0: one done every 2 cycles
    if0.req = 1'b1; if0.we = 1'b0; if0.size = 3'd2; if0.addr = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("hs0_done_c%0d", i), {31'd0, if0.done}, {31'd0, hs_exp(i, 0)});
    end
    if0.req = 1'b0;

    // Back-to-back requests, WAIT_CYCLES=3: one done every 5 cycles
    if3.req = 1'b1; if3.we = 1'b0; if3.size = 3'd2; if3.addr = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("hs3_done_c%0d", i), {31'd0, if3.done}, {31'd0, hs_exp(i, 3)});
    end
    if3.req = 1'b0;
    for (int i = 0; i < 10 && if3.busy; i++) @(negedge clk);

    // Reset during WAIT drops the store
    txn3(1'b1, 3'd2, 32'h20, 32'hA5A5A5A5, got, err, rd);
    check("w3_store_done", {31'd0, got}, 32'd1);
    check("w3_store_err",  {31'd0, err}, 32'd0);
    for (int i = 0; i < 10 && if3.busy; i++) @(negedge clk);
    if3.req = 1'b1; if3.we = 1'b1; if3.size = 3'd2; if3.addr = 32'h20; if3.write_data = 32'h12345678;
    @(negedge clk);
    if3.req = 1'b0;
    rst_n3 = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, if3.busy}, 32'd0);
    rst_n3 = 1'b1;
    sawdone = 1'b0;
    repeat (6) begin @(negedge clk); sawdone |= if3.done; end
    check("midrst_no_done", {31'd0, sawdone}, 32'd0);
    txn3(1'b0, 3'd2, 32'h20, 32'd0, got, err, rd);
    check("midrst_load_done",  {31'd0, got}, 32'd1);
    check("midrst_load_rdata", rd, 32'hA5A5A5A5);

    // Reset coinciding with the commit edge also drops the store
    for (int i = 0; i < 10 && if3.busy; i++) @(negedge clk);
    if3.req = 1'b1; if3.we = 1'b1; if3.size = 3'd2; if3.addr = 32'h20; if3.write_data = 32'h0BADF00D;
    @(negedge clk);
    if3.req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n3 = 1'b0;
    @(negedge clk);
    check("commitrst_done", {31'd0, if3.done}, 32'd0);
    rst_n3 = 1'b1;
    @(negedge clk);
    txn3(1'b0, 3'd2, 32'h20, 32'd0, got, err, rd);
    check("commitrst_load_rdata", rd, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised byte-addressable data memory with a req/busy/done handshake, programmable wait states, and RISC-V-style sized accesses. Supported accesses are byte, half and word loads/stores, with load sign/zero extension. Misaligned, out-of-range and illegal-size accesses are flagged instead of silently aliasing. Sits between the core's load/store unit and on-chip RAM as the next-generation data memory.

## Interface

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; power of two, ≥ 4
- WAIT_CYCLES, 1, extra cycles between acceptance and response; 0–15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  1  request strobe
- we  in  1  1 = store, 0 = load
- size  in  3  encodings:
  - 000 LB/SB
  - 001 LH/SH
  - 010 LW/SW
  - 100 LBU
  - 101 LHU
  - any other code is illegal
- addr  in  32  byte address
- write_data  in  32  store data; low byte/half used for SB/SH
- busy  out  1  transaction in flight; req ignored while high
- done  out  1  one-cycle response pulse
- err  out  1  valid with done; access rejected
- read_data  out  32  load result, valid with done

## Operation

State machine: IDLE, WAIT, RESP. busy = (state != IDLE).

IDLE:
- req=1 accepts the request; addr, we, size and write_data are latched.
- Next state is WAIT if WAIT_CYCLES>0, else RESP.
- req=0 stays in IDLE.

WAIT:
- Down-counter loaded with WAIT_CYCLES-1 at acceptance.
- Moves to RESP after the count reaches 0; WAIT is occupied for exactly WAIT_CYCLES cycles.

Transition into RESP:
- Error check: err_next = illegal size, OR misaligned (half with addr[0]=1; word with addr[1:0]≠0), OR addr + bytes > DEPTH_BYTES, with bytes = 1/2/4. The addition is done in 33 bits, so no wraparound.
- If err_next=0 and we=1: memory bytes are written, little-endian. write_data[7:0] goes to addr, [15:8] to addr+1, etc. Only 1/2/4 bytes change.
- If err_next=0 and we=0: bytes are read and extended:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW returns all 32 bits.
  - read_data is registered.
- If err_next=1: memory is untouched and read_data is set to 0.
- For stores, read_data is set to 0.
- Address 0 is an ordinary location.

RESP:
- done=1 and err=err_next for one cycle; next state is IDLE.
- req during RESP is ignored, since busy is still high.

Outputs and memory contents:
- read_data and err hold their values until the next RESP.
- done is high only in RESP.
- Memory contents are not initialised by reset.

Reset (rst_n=0 at a rising edge):
- State returns to IDLE and the counter clears.
- done=0, err=0, busy=0, read_data=0.
- A pending store is dropped, even if reset coincides with the commit edge.

## Timing

- Request accepted at edge N (state IDLE, req=1).
- busy is high for cycles N+1 … N+1+WAIT_CYCLES.
- done, err and read_data are valid in cycle N+1+WAIT_CYCLES.
- Earliest next acceptance is edge N+2+WAIT_CYCLES, giving a throughput of one access per WAIT_CYCLES+2 cycles.
- A store is visible to any load accepted after its done cycle.
- Inputs only need to be stable at the accepting edge.
- No combinational path from inputs to outputs.

## Test plan

- Reset: hold rst_n=0 for 2 cycles with req=1 → busy=0, done=0, err=0, read_data=0 throughout.
- Word round trip (WAIT_CYCLES=1):
  - SW 0xDEADBEEF @0x10, then LW @0x10 → done 2 cycles after each accept.
  - read_data=0xDEADBEEF, err=0.
- Sized loads and stores: after the word above:
  - LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE.
  - LH @0x10 → 0xFFFFBEEF; LHU @0x12 → 0x0000DEAD.
  - SB 0x55 @0x11, then LW @0x10 → 0xDEAD55EF.
- Errors:
  - LW @0x02 → err=1, read_data=0.
  - SH @0x0F → err=1, memory unchanged.
  - LW @DEPTH_BYTES-2 → err=1.
  - size=011 → err=1.
  - LW @DEPTH_BYTES-4 → err=0.
- Handshake: req held high continuously with WAIT_CYCLES=0 and 3 → accepts every 2 and every 5 cycles respectively, done exactly one cycle each.
- Reset mid-operation: SW 0x12345678 @0x20 (WAIT_CYCLES=3), rst_n=0 during WAIT → no done; a later LW @0x20 returns the prior contents.
